// File: rtl/data_mem_if.sv
// Request/response bus between the LC3 core (master) and the data-memory responder (slave).
// addr_err exists only when DATA_MEM_ADDR_CHECK_EN is defined.
interface data_mem_if;
  logic        mem_access;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic        Data_rd;
  logic [15:0] Data_dout;
  logic        complete_data;
`ifdef DATA_MEM_ADDR_CHECK_EN
  logic        addr_err;

  modport master (
    output mem_access, Data_addr, Data_din, Data_rd,
    input  Data_dout, complete_data, addr_err
  );
  modport slave (
    input  mem_access, Data_addr, Data_din, Data_rd,
    output Data_dout, complete_data, addr_err
  );
`else
  modport master (
    output mem_access, Data_addr, Data_din, Data_rd,
    input  Data_dout, complete_data
  );
  modport slave (
    input  mem_access, Data_addr, Data_din, Data_rd,
    output Data_dout, complete_data
  );
`endif
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port 2^DEPTH_LOG2 x 16 data memory with programmable wait states for the LC3 core.
// Optional upper-address checking enabled by defining DATA_MEM_ADDR_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for mem_access; request latched on accept
// WAIT   | counting down wait states; access performed when counter is 0
// DONE   | completion issued; wait for mem_access to drop
module data_mem_ctrl #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input logic       clock,
  input logic       reset,
  data_mem_if.slave bus
);

  localparam int         DEPTH  = 2 ** DEPTH_LOG2;
  localparam logic [3:0] LAT    = 4'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [15:0]           din_q, din_d;
  logic                  rd_q, rd_d;
  logic [15:0]           dout_q, dout_d;
  logic                  cmpl_q, cmpl_d;
  logic                  hi_bad;
  logic                  access_now;
  logic                  mem_we;

  logic [15:0] mem [DEPTH];

`ifdef DATA_MEM_ADDR_CHECK_EN
  logic hi_q, hi_d;
  logic err_q, err_d;

  assign hi_bad       = hi_q;
  assign bus.addr_err = err_q;
`else
  assign hi_bad = 1'b0;
`endif

  assign access_now = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we     = access_now && !rd_q && !hi_bad;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    din_d   = din_q;
    rd_d    = rd_q;
    dout_d  = dout_q;
    cmpl_d  = 1'b0;
`ifdef DATA_MEM_ADDR_CHECK_EN
    hi_d    = hi_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.mem_access) begin
          idx_d   = bus.Data_addr[DEPTH_LOG2-1:0];
          din_d   = bus.Data_din;
          rd_d    = bus.Data_rd;
          cnt_d   = LAT;
          state_d = S_WAIT;
`ifdef DATA_MEM_ADDR_CHECK_EN
          hi_d    = (bus.Data_addr >> DEPTH_LOG2) != 16'd0;
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cmpl_d  = 1'b1;
          state_d = S_DONE;
          if (rd_q) dout_d = hi_bad ? 16'h0000 : mem[idx_q];
`ifdef DATA_MEM_ADDR_CHECK_EN
          err_d   = hi_q;
`endif
        end
      end
      S_DONE: begin
        // Held mem_access must not start a second access
        if (!bus.mem_access) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      din_q   <= 16'h0000;
      rd_q    <= 1'b0;
      dout_q  <= 16'h0000;
      cmpl_q  <= 1'b0;
`ifdef DATA_MEM_ADDR_CHECK_EN
      hi_q    <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      dout_q  <= dout_d;
      cmpl_q  <= cmpl_d;
`ifdef DATA_MEM_ADDR_CHECK_EN
      hi_q    <= hi_d;
      err_q   <= err_d;
`endif
    end
  end

  // Array is deliberately not reset
  always_ff @(posedge clock) begin
    if (mem_we) mem[idx_q] <= din_q;
  end

  assign bus.Data_dout     = dout_q;
  assign bus.complete_data = cmpl_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: LATENCY=0 and LATENCY=2 instances checked against an array model.
module tb_data_mem_ctrl;

  localparam int LAT0 = 0;
  localparam int LAT1 = 2;
`ifdef DATA_MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clock;
  logic reset;

  data_mem_if bus0 ();
  data_mem_if bus1 ();

  data_mem_ctrl #(.DEPTH_LOG2(8), .LATENCY(LAT0)) u_dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );
  data_mem_ctrl #(.DEPTH_LOG2(8), .LATENCY(LAT1)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem_m  [2][256];
  bit          wr_m   [2][256];
  logic [15:0] dexp   [2];

  task automatic drive(input int w, input logic ma, input logic [15:0] a,
                       input logic [15:0] d, input logic rd);
    if (w == 1) begin
      bus1.mem_access = ma; bus1.Data_addr = a; bus1.Data_din = d; bus1.Data_rd = rd;
    end else begin
      bus0.mem_access = ma; bus0.Data_addr = a; bus0.Data_din = d; bus0.Data_rd = rd;
    end
  endtask

  function automatic logic get_cmpl(input int w);
    return (w == 1) ? bus1.complete_data : bus0.complete_data;
  endfunction

  function automatic logic [15:0] get_dout(input int w);
    return (w == 1) ? bus1.Data_dout : bus0.Data_dout;
  endfunction

  function automatic void set_ma(input int w, input logic ma);
    if (w == 1) bus1.mem_access = ma; else bus0.mem_access = ma;
  endfunction

  // One complete transaction with model update and latency/data/pulse checks
  task automatic access(input int w, input logic [15:0] a, input logic [15:0] d,
                        input logic rd, input bit scramble, input bit drop_early,
                        input int hold, input string tag);
    int          lat_exp;
    int          found;
    int          extra;
    bit          hi;
    logic [7:0]  idx;
    lat_exp = ((w == 1) ? LAT1 : LAT0) + 1;
    hi      = (a[15:8] != 8'h00);
    idx     = a[7:0];
    if (rd) dexp[w] = (CHK && hi) ? 16'h0000 : mem_m[w][idx];
    else if (!(CHK && hi)) begin
      mem_m[w][idx] = d;
      wr_m[w][idx]  = 1'b1;
    end

    @(negedge clock);
    drive(w, 1'b1, a, d, rd);
    found = -1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clock);
      if (get_cmpl(w)) begin
        found = k;
        break;
      end
      if (scramble) drive(w, !(drop_early), 16'($urandom), 16'($urandom), rd);
      else if (drop_early) set_ma(w, 1'b0);
    end
    tests++;
    if (found != lat_exp) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", tag, found, lat_exp);
    end
    if (found >= 0) begin
      tests++;
      if (get_dout(w) !== dexp[w]) begin
        fails++;
        $display("FAIL %s dout: got %h, expected %h", tag, get_dout(w), dexp[w]);
      end
`ifdef DATA_MEM_ADDR_CHECK_EN
      tests++;
      if (((w == 1) ? bus1.addr_err : bus0.addr_err) !== hi) begin
        fails++;
        $display("FAIL %s addr_err: got %b, expected %b", tag,
                 (w == 1) ? bus1.addr_err : bus0.addr_err, hi);
      end
`endif
    end
    extra = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      if (get_cmpl(w)) extra++;
    end
    if (hold > 0) begin
      tests++;
      if (extra != 0) begin
        fails++;
        $display("FAIL %s held_retrigger: got %0d extra pulses, expected 0", tag, extra);
      end
    end
    drive(w, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clock);
    tests++;
    if (get_cmpl(w) !== 1'b0 || get_dout(w) !== dexp[w]) begin
      fails++;
      $display("FAIL %s after_done: got cmpl=%b dout=%h, expected cmpl=0 dout=%h",
               tag, get_cmpl(w), get_dout(w), dexp[w]);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    for (int w = 0; w < 2; w++) begin
      tests++;
      if (get_cmpl(w) !== 1'b0) begin
        fails++;
        $display("FAIL reset_cmpl[%0d]: got %b, expected 0", w, get_cmpl(w));
      end
      tests++;
      if (get_dout(w) !== 16'h0000) begin
        fails++;
        $display("FAIL reset_dout[%0d]: got %h, expected 0000", w, get_dout(w));
      end
      dexp[w] = 16'h0000;
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    access(1, 16'h0010, 16'hBEEF, 1'b0, 0, 0, 0, "l2_write");
    access(1, 16'h0010, 16'h0000, 1'b1, 0, 0, 0, "l2_read");
  endtask

  task automatic test_hold();
    access(1, 16'h0010, 16'h0000, 1'b1, 0, 0, 10, "hold_read");
  endtask

  task automatic test_lat0();
    access(0, 16'h0020, 16'h1234, 1'b0, 0, 0, 0, "l0_write");
    access(0, 16'h0020, 16'h0000, 1'b1, 0, 0, 0, "l0_read");
    access(0, 16'h0020, 16'h5555, 1'b0, 0, 0, 0, "l0_write_keep");
    access(0, 16'h0020, 16'h0000, 1'b1, 0, 0, 0, "l0_read_new");
  endtask

  task automatic test_alias();
    for (int w = 0; w < 2; w++) begin
      access(w, 16'h0005, 16'h1111, 1'b0, 0, 0, 0, "alias_pre");
      access(w, 16'h0105, 16'hAAAA, 1'b0, 0, 0, 0, "alias_write");
      access(w, 16'h0005, 16'h0000, 1'b1, 0, 0, 0, "alias_read");
    end
  endtask

  task automatic test_reset_mid_wait();
    int pulses;
    access(1, 16'h0030, 16'h3030, 1'b0, 0, 0, 0, "rst_pre");
    @(negedge clock);
    drive(1, 1'b1, 16'h0030, 16'h7777, 1'b0);
    @(negedge clock);
    reset  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (get_cmpl(1)) pulses++;
      if (k == 1) drive(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    end
    reset   = 1'b1;
    dexp[0] = 16'h0000;
    dexp[1] = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (get_cmpl(1)) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL rst_mid_wait_pulse: got %0d pulses, expected 0", pulses);
    end
    access(1, 16'h0030, 16'h0000, 1'b1, 0, 0, 0, "rst_mid_wait_read");
  endtask

  task automatic test_scramble();
    for (int w = 0; w < 2; w++) begin
      access(w, 16'h0041, 16'hC0DE, 1'b0, 1, 0, 0, "scr_write");
      access(w, 16'h0041, 16'h0000, 1'b1, 1, 0, 0, "scr_read");
    end
  endtask

  task automatic test_drop_early();
    access(1, 16'h0052, 16'h0F0F, 1'b0, 0, 1, 0, "drop_write");
    access(1, 16'h0052, 16'h0000, 1'b1, 0, 1, 0, "drop_read");
    access(0, 16'h0052, 16'h00FF, 1'b0, 0, 1, 0, "drop_write0");
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic        rd;
    for (int n = 0; n < 60; n++) begin
      int w;
      w = n % 2;
      a = {8'h00, 8'($urandom_range(96, 111))};
      if ($urandom_range(0, 3) == 0) a[15:8] = 8'($urandom_range(1, 255));
      rd = 1'($urandom_range(0, 1));
      if (rd && !wr_m[w][a[7:0]] && !(CHK && a[15:8] != 8'h00)) rd = 1'b0;
      access(w, a, 16'($urandom), rd, bit'($urandom_range(0, 1)), 0, 0, "random");
    end
  endtask

  initial begin
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 256; i++) begin
        wr_m[w][i]  = 1'b0;
        mem_m[w][i] = 16'h0000;
      end
    reset = 1'b0;
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    test_reset();
    test_basic();
    test_hold();
    test_lat0();
    test_alias();
    test_reset_mid_wait();
    test_scramble();
    test_drop_early();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory responder for the LC3 datapath: consumes the Data_addr / Data_din / Data_rd request bus driven by the core during its memory-access state.
- Performs a single-port word read or write into an internal 2^DEPTH_LOG2 x 16 array after a programmable wait-state delay.
- Returns read data on Data_dout and pulses complete_data to release the core from its memory state.

Parameters:
- DEPTH_LOG2, 8, number of Data_addr low bits used to index the array (256 words).
- LATENCY, 2, wait-state cycles inserted between accept and completion (legal range 0..15).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- mem_access  input  1  core is in a memory-access state; request qualifier.
- Data_addr  input  16  word address.
- Data_din  input  16  write data.
- Data_rd  input  1  1 = read, 0 = write.
- Data_dout  output  16  read data.
- complete_data  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, wait counter=0, complete_data=0, Data_dout=16'h0000, latched request cleared. Array contents are not reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Condition: mem_access==1 at a rising edge.
  - Action: latch Data_addr, Data_din, Data_rd; load counter=LATENCY; go to WAIT.
- WAIT, counter!=0:
  - Decrement the counter each edge.
  - Inputs are ignored; the latched copies are used.
- WAIT, counter==0: at the next edge:
  - Perform the access at index addr_q[DEPTH_LOG2-1:0].
  - Read: Data_dout <= mem[idx]. Write: mem[idx] <= din_q; Data_dout unchanged.
  - Assert complete_data for exactly one cycle; go to DONE.
- Latency: complete_data is high in the cycle beginning LATENCY+1 edges after the accept edge.
  - LATENCY=0 gives a 1-cycle response.
- DONE:
  - Stay while mem_access==1; no re-trigger on a held mem_access.
  - Return to IDLE when mem_access==0.
  - Earliest next accept is the edge after that.
- mem_access dropped during WAIT: the access still completes and complete_data still pulses (the core does not abort).
- Data_dout holds the last read value until the next read completes, including across writes.
- Address aliasing: Data_addr bits [15:DEPTH_LOG2] are ignored; e.g. 16'h0105 and 16'h0005 hit the same word at DEPTH_LOG2=8.
- Read-after-write to the same address in back-to-back accesses returns the new data; there is no bypass requirement since accesses are serialized.
- Reset asserted mid-WAIT: the pending write is dropped (array unchanged), no complete_data pulse, FSM returns to IDLE.
- complete_data is never high in two consecutive cycles.

Optional Feature:
- Macro: DATA_MEM_ADDR_CHECK_EN.
- When defined:
  - Adds output addr_err (1 bit, reset 0).
  - If the latched Data_addr[15:DEPTH_LOG2] is nonzero, addr_err pulses in the same cycle as complete_data.
  - Writes are suppressed; reads return 16'h0000 on Data_dout.
- When undefined:
  - No addr_err port.
  - Upper address bits alias silently as described above.

Test Plan:
- LATENCY=2, after reset: write 16'hBEEF at Data_addr=16'h0010 (mem_access=1 at edge 0) -> complete_data high in the cycle after edge 3 only.
  - Then read 16'h0010 -> Data_dout=16'hBEEF coincident with complete_data.
- Reset held low: check complete_data=0 and Data_dout=0. Then hold mem_access=1 for 10 cycles on a read -> exactly one complete_data pulse, no second access until mem_access drops.
- LATENCY=0: read 16'h0020 (previously written 16'h1234) -> complete_data and Data_dout=16'h1234 one cycle after accept.
  - Then write 16'h5555 to the same address -> Data_dout stays 16'h1234.
- Write 16'hAAAA to 16'h0105, then read 16'h0005 -> Data_dout=16'hAAAA (alias).
  - With DATA_MEM_ADDR_CHECK_EN: write is suppressed, addr_err pulses; reading 16'h0005 returns the old value.
- Start a write of 16'h7777 to 16'h0030, assert reset during WAIT -> no complete_data pulse. After reset, reading 16'h0030 returns the prior contents, not 16'h7777.
- Change Data_addr and Data_din on every cycle during WAIT -> the access uses only the values latched at the accept edge.
